// File: rtl/flap_input_ctrl.sv
// Multi-source jump-input conditioner: synchronise, debounce, edge-detect and rate-limit flaps.
// Optional auto-repeat while the flapping channel stays held: define FLAP_AUTOREPEAT_EN.
module flap_input_ctrl #(
  parameter int N_CH            = 2,
  parameter int SRC_W           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLDOFF_CYCLES  = 2500000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  raw_in,
  input  logic [N_CH-1:0]  enable_mask,
  output logic [N_CH-1:0]  level_out,
  output logic             flap_pulse,
  output logic [SRC_W-1:0] src_id,
  output logic [7:0]       flap_count,
  output logic [7:0]       drop_count
);

  localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] HOLD_LOAD = 24'(HOLDOFF_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_nx;
  logic [23:0]      hcnt, hcnt_nx;
  logic             flap_nx;
  logic [SRC_W-1:0] src_nx, low_idx;
  logic [7:0]       fc_nx, dc_nx;
  logic [N_CH-1:0]  s1, s2, lvl_d, rise;
  logic [23:0]      db_cnt [N_CH];

  // Synchroniser, debounce and level delay for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      lvl_d     <= '0;
      level_out <= '0;
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
    end else begin
      s1    <= raw_in;
      s2    <= s1;
      lvl_d <= level_out;
      for (int i = 0; i < N_CH; i++) begin
        if (s2[i] == level_out[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level_out[i] <= s2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 24'd1;
        end
      end
    end
  end

  assign rise = level_out & ~lvl_d & enable_mask;

  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (rise[i]) low_idx = SRC_W'(i);
  end

`ifdef FLAP_AUTOREPEAT_EN
  localparam logic [23:0] REP_LOAD = 24'(REPEAT_CYCLES - 1);
  logic rep_ok;

  // Repeat only while the channel that flapped is still held and enabled
  always_comb begin
    rep_ok = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (src_id == SRC_W'(i)) rep_ok = level_out[i] & enable_mask[i];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hcnt       <= '0;
      flap_pulse <= 1'b0;
      src_id     <= '0;
      flap_count <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_nx;
      hcnt       <= hcnt_nx;
      flap_pulse <= flap_nx;
      src_id     <= src_nx;
      flap_count <= fc_nx;
      drop_count <= dc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    flap_nx  = 1'b0;
    src_nx   = src_id;
    fc_nx    = flap_count;
    dc_nx    = drop_count;
    case (state)
      IDLE: begin
        if (|rise) begin
          flap_nx  = 1'b1;
          src_nx   = low_idx;
          fc_nx    = flap_count + 8'd1;
          hcnt_nx  = HOLD_LOAD;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        // One drop per cycle however many channels rise together
        if ((|rise) && (drop_count != 8'hFF)) dc_nx = drop_count + 8'd1;
        if (hcnt != 24'd0) begin
          hcnt_nx = hcnt - 24'd1;
        end else begin
`ifdef FLAP_AUTOREPEAT_EN
          if (rep_ok) begin
            flap_nx = 1'b1;
            fc_nx   = flap_count + 8'd1;
            hcnt_nx = REP_LOAD;
          end else begin
            state_nx = IDLE;
          end
`else
          state_nx = IDLE;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flap_input_ctrl.sv
// Self-checking bench for flap_input_ctrl: directed scenarios plus randomized stress
// against a timestamp-based reference model.
module tb_flap_input_ctrl;
  localparam int N_CH = 3;
  localparam int SRC_W = 3;
  localparam int DB = 4;
  localparam int HO = 8;
  localparam int RP = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N_CH-1:0]  raw_in = '0;
  logic [N_CH-1:0]  enable_mask = 3'b111;
  logic [N_CH-1:0]  level_out;
  logic             flap_pulse;
  logic [SRC_W-1:0] src_id;
  logic [7:0]       flap_count, drop_count;

  flap_input_ctrl #(
    .N_CH(N_CH), .SRC_W(SRC_W), .DEBOUNCE_CYCLES(DB),
    .HOLDOFF_CYCLES(HO), .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .enable_mask(enable_mask),
    .level_out(level_out), .flap_pulse(flap_pulse), .src_id(src_id),
    .flap_count(flap_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n = 0;
  int flaps[$];
  int fsrc[$];

  // Reference model state
  logic [N_CH-1:0] m_s1, m_s2, m_lvl, m_lvl_prev;
  int m_run[N_CH];
  int hold_end, m_src, m_fc, m_dc;
  logic m_flap;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0;
    for (int i = 0; i < N_CH; i++) m_run[i] = 0;
    hold_end = -1; m_src = 0; m_fc = 0; m_dc = 0; m_flap = 1'b0;
  endtask

  // Flap acceptance is decided from the time of the last flap: edges up to
  // last_flap + period belong to the hold-off window.
  task automatic model_step();
    logic [N_CH-1:0] rise, old_lvl;
    rise = m_lvl & ~m_lvl_prev & enable_mask;
    m_flap = 1'b0;
    if (n <= hold_end) begin
      if (rise != 0 && m_dc < 255) m_dc++;
`ifdef FLAP_AUTOREPEAT_EN
      if (n == hold_end && m_lvl[m_src] && enable_mask[m_src]) begin
        m_flap = 1'b1; m_fc = (m_fc + 1) % 256; hold_end = n + RP;
      end
`endif
    end else if (rise != 0) begin
      m_flap = 1'b1;
      for (int i = N_CH - 1; i >= 0; i--) if (rise[i]) m_src = i;
      m_fc = (m_fc + 1) % 256;
      hold_end = n + HO;
    end
    old_lvl = m_lvl;
    for (int i = 0; i < N_CH; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin m_lvl[i] = m_s2[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    m_lvl_prev = old_lvl;
    m_s2 = m_s1;
    m_s1 = raw_in;
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    model_step();
    #1;
    check_val("level", level_out, m_lvl);
    check_val("flap", flap_pulse, m_flap);
    check_val("src", src_id, m_src);
    check_val("fcnt", flap_count, m_fc);
    check_val("dcnt", drop_count, m_dc);
    if (flap_pulse) begin flaps.push_back(n); fsrc.push_back(src_id); end
  endtask

  task automatic run_until(input int e);
    while (n < e) step();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_level", level_out, 0);
    check_val("rst_flap", flap_pulse, 0);
    check_val("rst_src", src_id, 0);
    check_val("rst_fcnt", flap_count, 0);
    check_val("rst_dcnt", drop_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    n = 0;
    flaps.delete();
    fsrc.delete();
  endtask

  initial begin
    int left[N_CH];
    logic seen;
    model_reset();

    // Clean press on ch0, held then released
    apply_reset();
    run_until(9);
    raw_in = 3'b001;
    run_until(14);
    check_val("t1_lvl_e14", level_out[0], 0);
    step();
    check_val("t1_lvl_e15", level_out[0], 1);
    run_until(35);
    raw_in = 3'b000;
    run_until(60);
`ifdef FLAP_AUTOREPEAT_EN
    check_val("t1_nflaps", flaps.size(), 4);
    if (flaps.size() == 4) begin
      check_val("t1_rep1", flaps[1], 24);
      check_val("t1_rep2", flaps[2], 30);
      check_val("t1_rep3", flaps[3], 36);
    end
    check_val("t1_fcnt", flap_count, 4);
`else
    check_val("t1_nflaps", flaps.size(), 1);
    check_val("t1_fcnt", flap_count, 1);
`endif
    if (flaps.size() > 0) begin
      check_val("t1_edge", flaps[0], 16);
      check_val("t1_src", fsrc[0], 0);
    end

    // Ch1 glitches shorter than the debounce window
    apply_reset();
    run_until(2);
    seen = 1'b0;
    for (int r = 0; r < 5; r++) begin
      raw_in = 3'b010;
      repeat (3) begin step(); seen |= |level_out; end
      raw_in = 3'b000;
      repeat (3) begin step(); seen |= |level_out; end
    end
    run_until(50);
    check_val("t2_level", seen, 0);
    check_val("t2_nflaps", flaps.size(), 0);

    // Ch1 and ch2 pressed together
    apply_reset();
    run_until(9);
    raw_in = 3'b110;
    run_until(30);
    check_val("t3_nflaps", flaps.size(), 1);
    if (flaps.size() > 0) check_val("t3_src", fsrc[0], 1);
    check_val("t3_fcnt", flap_count, 1);
    check_val("t3_dcnt", drop_count, 0);
    raw_in = 3'b000;
    run_until(45);

    // Ch2 rises during hold-off, then re-pressed after it
    apply_reset();
    run_until(9);  raw_in = 3'b001;
    run_until(11); raw_in = 3'b101;
    run_until(15); raw_in = 3'b100;
    run_until(20); raw_in = 3'b000;
    run_until(29); raw_in = 3'b100;
    run_until(45);
    check_val("t4_nflaps", flaps.size(), 2);
    if (flaps.size() == 2) begin
      check_val("t4_edge0", flaps[0], 16);
      check_val("t4_edge1", flaps[1], 36);
      check_val("t4_src1", fsrc[1], 2);
    end
    check_val("t4_dcnt", drop_count, 1);
    check_val("t4_fcnt", flap_count, 2);
    raw_in = 3'b000;
    run_until(60);

    // Masked channel, then reset in the middle of hold-off
    apply_reset();
    enable_mask = 3'b110;
    run_until(9);  raw_in = 3'b001;
    run_until(25);
    check_val("t5_lvl0", level_out[0], 1);
    check_val("t5_nflaps", flaps.size(), 0);
    check_val("t5_fcnt", flap_count, 0);
    check_val("t5_dcnt", drop_count, 0);
    enable_mask = 3'b111;
    raw_in = 3'b011;
    run_until(35);
    check_val("t5_flap_pre", flaps.size(), 1);
    apply_reset();
    run_until(12);
    check_val("t5_post_nflaps", flaps.size(), 1);
    if (flaps.size() > 0) begin
      check_val("t5_post_edge", flaps[0], 7);
      check_val("t5_post_src", fsrc[0], 0);
    end
    raw_in = 3'b000;
    run_until(30);

    // Randomized activity: mixed glitches and presses, changing masks
    apply_reset();
    for (int i = 0; i < N_CH; i++) left[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (left[i] == 0) begin
          raw_in[i] = $urandom_range(0, 1);
          left[i] = $urandom_range(1, 25);
        end else left[i]--;
      end
      if (c % 300 == 0) enable_mask = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      step();
    end

    // Dense toggling to drive drop saturation and flap count wrap
    enable_mask = 3'b111;
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (left[i] == 0) begin
          raw_in[i] = ~raw_in[i];
          left[i] = $urandom_range(5, 7);
        end else left[i]--;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flap_input_ctrl.md
# flap_input_ctrl

Parametrised multi-source jump-input conditioner for the Flappy Bird game. It sits between the raw jump sources (push buttons, PS/2 spacebar strobe, future pads) and `game`, and drives `game.btn_pressed` from `flap_pulse`. It replaces the single-register button sampling and OR-merge in `top` with:
- per-channel synchronisation and debounce;
- rising-edge detection with masking;
- a hold-off state machine that rate-limits flaps, plus optional auto-repeat;
- event counters for the LEDs.

## Interface
Parameters:
- `N_CH`, 2: number of input channels, 1..8.
- `SRC_W`, 3: width of `src_id`; must satisfy 2^SRC_W ≥ N_CH.
- `DEBOUNCE_CYCLES`, 500000: cycles an input must be stable before it is accepted (10 ms at 50 MHz); ≥1, < 2^24.
- `HOLDOFF_CYCLES`, 2500000: minimum hold-off after a flap (50 ms); ≥1, < 2^24.
- `REPEAT_CYCLES`, 5000000: auto-repeat period; ≥1, < 2^24. Used only with `FLAP_AUTOREPEAT_EN`.

Ports:
- `clk`, in, 1: 50 MHz board clock; the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `raw_in`, in, N_CH: asynchronous jump inputs, active high.
- `enable_mask`, in, N_CH: 1 = channel may generate flaps.
- `level_out`, out, N_CH: debounced level per channel.
- `flap_pulse`, out, 1: one-cycle flap strobe.
- `src_id`, out, SRC_W: channel index of the most recent flap.
- `flap_count`, out, 8: number of flaps issued; wraps modulo 256.
- `drop_count`, out, 8: number of rises rejected during hold-off; saturates at 255.

## Operation
- Reset: all registers clear asynchronously.
  - `level_out`=0, `flap_pulse`=0, `src_id`=0, `flap_count`=0, `drop_count`=0.
  - State=IDLE; all counters=0.
- Synchroniser: two flops per channel (`s1`, `s2`).
- Debounce, per channel, 24-bit counter:
  - If `s2` equals `level_out`, the counter clears.
  - Otherwise the counter increments.
  - When a mismatch is seen with counter = DEBOUNCE_CYCLES-1, `level_out` takes `s2` and the counter clears.
- Rise detection: `rise[i] = level_out[i] & ~lvl_d[i] & enable_mask[i]`, where `lvl_d` is a one-cycle delay of `level_out`.
  - Masking does not affect debounce or `level_out`.
  - A masked rise is ignored and not counted.
- State machine, with a 24-bit hold-off counter `hcnt`:
  - IDLE:
    - If any rise is present, register `flap_pulse`=1 and `src_id` = lowest set index, increment `flap_count`, load `hcnt`=HOLDOFF_CYCLES-1, go to HOLD.
    - Simultaneous rises merge into one flap; the other rises are not counted as drops.
  - HOLD:
    - Any rise present increments `drop_count` by 1 per cycle (saturating), regardless of how many channels rise in that cycle.
    - If `hcnt`≠0, decrement `hcnt`.
    - If `hcnt`=0, go to IDLE (see Configuration for the auto-repeat exception).
- `flap_pulse` is 0 in every cycle not described above.
- A channel held high through reset release reads as a fresh press and produces a flap after debounce. This is the required behaviour.

## Timing
- `raw_in[i]` is stable high from before clock edge k onward:
  - `s2` goes high at edge k+1.
  - `level_out[i]` goes high at edge k+1+DEBOUNCE_CYCLES.
  - `flap_pulse` is high for the single cycle following edge k+2+DEBOUNCE_CYCLES (when in IDLE).
- Release uses the same debounce latency; a release produces no flap.
- A flap at edge t enters HOLD. Without auto-repeat, the state returns to IDLE at edge t+HOLDOFF_CYCLES. The next flap is therefore no earlier than edge t+HOLDOFF_CYCLES+1.
- A rise that occurs while in HOLD is dropped permanently; it is not queued.
- `src_id` and `flap_count` update on the same edge that raises `flap_pulse`, and hold between flaps.
- Every output is registered; there are no combinational paths from input to output.

## Configuration
- Macro: `FLAP_AUTOREPEAT_EN`.
- Defined, in HOLD with `hcnt`=0:
  - If `level_out[src_id]` and `enable_mask[src_id]` are both 1: issue `flap_pulse` with the same `src_id`, increment `flap_count`, load `hcnt`=REPEAT_CYCLES-1, stay in HOLD.
  - Otherwise go to IDLE.
  - With a continuous hold, flaps occur at t, t+HOLDOFF_CYCLES, then every REPEAT_CYCLES.
- Undefined:
  - No repeat logic is compiled in; `REPEAT_CYCLES` is ignored.
  - A held input yields exactly one flap per press.

## Test plan
Bench parameters: N_CH=3, DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8, REPEAT_CYCLES=6, mask=3'b111, press stable from edge 10.
- Clean press on ch0 held → `level_out[0]` rises at edge 15; `flap_pulse` high only after edge 16; `src_id`=0; `flap_count`=1; with the macro undefined, no further flaps.
- Ch1 glitch high for 3 cycles, then 3 low, repeated 5 times → `level_out`=0 throughout; `flap_pulse` never asserts.
- Ch1 and ch2 pressed on the same edge → exactly one flap with `src_id`=1; `flap_count`=1; `drop_count`=0.
- Ch0 flap at edge 16, ch2 pressed so that it rises during HOLD → `drop_count`=1, no flap; a ch2 re-press after edge 24 → flap with `src_id`=2.
- `enable_mask`=3'b110 with ch0 pressed → `level_out[0]` rises, no flap, counters unchanged. Separately, assert `rst_n` low mid-HOLD → all outputs 0 immediately; state IDLE after release.
- `FLAP_AUTOREPEAT_EN` defined, ch0 held → flaps after edges 16, 24, 30 and 36; releasing ch0 stops repeats and the state returns to IDLE.
